// File: rtl/uart_rx_frame_ctrl.sv
// Purpose : parses SYNC/ADDR/LEN/payload/CSUM frames from the UART receiver and
//           replays the verified payload as a burst of register writes.
// Latency : the first write comes one cycle after the CSUM byte. There is one write
//           per cycle. frame_ok follows the last write.
// Backpressure : none. The receiver cannot be stalled. One byte that arrives
//           during a drain is held and replayed as a HUNT byte when the drain ends.
// Ports   : clk/rst_n (sync, active-low); baud_tick, rx_valid, rx_data from the
//           receiver; wr_en/wr_addr/wr_data config-bus write; frame_ok/frame_err
//           pulses; err_code (1 len, 2 csum, 3 timeout, sticky); busy (not in HUNT).
module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_TICKS = 64,
  parameter logic [7:0] SYNC          = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int          TW        = $clog2(TIMEOUT_TICKS + 1);
  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT, S_ADDR, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN
  } state_t;

  state_t        state;
  logic [7:0]    base;
  logic [7:0]    len;
  logic [7:0]    idx;
  logic [7:0]    csum;
  logic [TW-1:0] tick_cnt;
  logic          hold_vld;
  logic [7:0]    hold_dat;
  logic [7:0]    buf_mem [0:MAX_LEN-1];

  logic timed;
  logic timeout_hit;
  logic in_vld;
  logic [7:0] in_dat;

  // The inter-byte timer only runs while a frame is being received.
  assign timed = (state == S_ADDR) || (state == S_LEN) ||
                 (state == S_PAYLOAD) || (state == S_CSUM);
  // A byte in the same cycle as the terminal tick wins over the timeout.
  assign timeout_hit = timed && baud_tick && !rx_valid && (tick_cnt == TICK_LAST);

  // In HUNT a byte held over from the drain takes precedence. A live byte in that
  // same cycle is dropped. The receiver cannot deliver two bytes that close together.
  always_comb begin
    in_vld = rx_valid;
    in_dat = rx_data;
    if (state == S_HUNT && hold_vld) begin
      in_vld = 1'b1;
      in_dat = hold_dat;
    end
  end

  // Payload storage. It has no reset because the contents are only read after a full frame.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_PAYLOAD && rx_valid) begin
      buf_mem[idx[AW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_HUNT;
      base      <= '0;
      len       <= '0;
      idx       <= '0;
      csum      <= '0;
      tick_cnt  <= '0;
      hold_vld  <= 1'b0;
      hold_dat  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (rx_valid) begin
        tick_cnt <= '0;
      end else if (baud_tick && timed) begin
        tick_cnt <= tick_cnt + TW'(1);
      end

      if (timeout_hit) begin
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        state     <= S_HUNT;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          S_HUNT: begin
            hold_vld <= 1'b0;
            if (in_vld && in_dat == SYNC) begin
              state <= S_ADDR;
              busy  <= 1'b1;
            end
          end
          S_ADDR: if (rx_valid) begin
            base  <= rx_data;
            csum  <= rx_data;
            state <= S_LEN;
          end
          S_LEN: if (rx_valid) begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              state     <= S_HUNT;
              busy      <= 1'b0;
            end else begin
              len   <= rx_data;
              idx   <= '0;
              csum  <= csum ^ rx_data;
              state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: if (rx_valid) begin
            csum <= csum ^ rx_data;
            idx  <= idx + 8'd1;
            if (idx == len - 8'd1) state <= S_CSUM;
          end
          S_CSUM: if (rx_valid) begin
            if (rx_data == csum) begin
              // Issue write 0 here so that the drain starts on the very next cycle.
              state   <= S_DRAIN;
              wr_en   <= 1'b1;
              wr_addr <= base;
              wr_data <= buf_mem[0];
              idx     <= 8'd1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= S_HUNT;
              busy      <= 1'b0;
            end
          end
          S_DRAIN: begin
            if (rx_valid) begin
              hold_vld <= 1'b1;
              hold_dat <= rx_data;
            end
            if (idx == len) begin
              frame_ok <= 1'b1;
              state    <= S_HUNT;
              busy     <= 1'b0;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= base + idx;
              wr_data <= buf_mem[idx[AW-1:0]];
              idx     <= idx + 8'd1;
            end
          end
          default: begin
            state <= S_HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Purpose : directed, table-driven check of uart_rx_frame_ctrl frame parsing and drain.
// Latency : expected write/status cycles are derived from the cycle of the last byte.
// Backpressure : not applicable. The bench drives bytes with fixed idle gaps.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  uart_rx_frame_ctrl #(.MAX_LEN(16), .TIMEOUT_TICKS(64), .SYNC(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_valid(rx_valid),
    .rx_data(rx_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Output monitor, sampled mid-cycle.
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         wc_q[$];
  int ok_n = 0, err_n = 0, both_n = 0, ok_cyc = 0, err_cyc = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
    end
    if (frame_ok)  begin ok_n++;  ok_cyc = cyc;  end
    if (frame_err) begin err_n++; err_cyc = cyc; end
    if (frame_ok && frame_err) both_n++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    ok_n = 0; err_n = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int c);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b; c = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_tick(output int c);
    @(posedge clk); #1;
    baud_tick = 1'b1; c = cyc;
    @(posedge clk); #1;
    baud_tick = 1'b0;
  endtask

  // Stimulus table. The checksum is the XOR of ADDR, LEN and the payload.
  // The wrap frame therefore closes with FD (FE^03^01^02^03).
  logic [7:0] stim [0:43] = '{
    8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13,          // 0  good
    8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14,          // 7  bad csum
    8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13,          // 14 good again
    8'hA5, 8'h10, 8'h00,                                      // 21 len 0
    8'hA5, 8'h10, 8'h11, 8'h22, 8'h33, 8'h13,                 // 24 len 17 + ignored
    8'h00, 8'hFF, 8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFD, // 30 wrap
    8'hA5, 8'h20, 8'h01, 8'hA5, 8'h84                         // 39 payload == SYNC
  };
  logic [7:0] exp_a [0:9] = '{8'h10, 8'h11, 8'h12, 8'h10, 8'h11, 8'h12,
                              8'hFE, 8'hFF, 8'h00, 8'h20};
  logic [7:0] exp_d [0:9] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33,
                              8'h01, 8'h02, 8'h03, 8'hA5};

  typedef struct {
    int         first;  // index into stim
    int         n;      // byte count
    int         wfirst; // index into exp_a/exp_d
    int         nw;     // expected writes
    int         ok;     // expected frame_ok pulses
    int         err;    // expected frame_err pulses
    int         epos;   // offending byte index within the vector (if err)
    logic [1:0] code;   // expected err_code afterwards
  } vec_t;

  vec_t vecs [0:6];
  int   bc [0:31];

  initial begin
    int c, cs, t, C;

    vecs[0] = '{0,  7, 0, 3, 1, 0, 0, 2'd0};
    vecs[1] = '{7,  7, 0, 0, 0, 1, 6, 2'd2};
    vecs[2] = '{14, 7, 3, 3, 1, 0, 0, 2'd2};
    vecs[3] = '{21, 3, 0, 0, 0, 1, 2, 2'd1};
    vecs[4] = '{24, 6, 0, 0, 0, 1, 2, 2'd1};
    vecs[5] = '{30, 9, 6, 3, 1, 0, 0, 2'd1};
    vecs[6] = '{39, 5, 9, 1, 1, 0, 0, 2'd1};

    // Reset state.
    idle(3);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_ok", {31'd0, frame_ok}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Table-driven frames.
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      for (int j = 0; j < vecs[v].n; j++) begin
        send_byte(stim[vecs[v].first + j], c);
        bc[j] = c;
      end
      idle(24);
      chk($sformatf("v%0d_nwr", v), wa_q.size(), vecs[v].nw);
      for (int k = 0; k < vecs[v].nw && k < wa_q.size(); k++) begin
        chk($sformatf("v%0d_addr%0d", v, k), {24'd0, wa_q[k]}, {24'd0, exp_a[vecs[v].wfirst + k]});
        chk($sformatf("v%0d_data%0d", v, k), {24'd0, wd_q[k]}, {24'd0, exp_d[vecs[v].wfirst + k]});
        chk($sformatf("v%0d_wcyc%0d", v, k), wc_q[k], bc[vecs[v].n - 1] + 1 + k);
      end
      chk($sformatf("v%0d_ok", v), ok_n, vecs[v].ok);
      chk($sformatf("v%0d_err", v), err_n, vecs[v].err);
      chk($sformatf("v%0d_code", v), {30'd0, err_code}, {30'd0, vecs[v].code});
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
      if (vecs[v].ok > 0 && ok_n > 0)
        chk($sformatf("v%0d_okcyc", v), ok_cyc, bc[vecs[v].n - 1] + 1 + vecs[v].nw);
      if (vecs[v].err > 0 && err_n > 0)
        chk($sformatf("v%0d_errcyc", v), err_cyc, bc[vecs[v].epos] + 1);
    end

    // Timeout: 64 ticks after ADDR with no further byte.
    clear_mon();
    send_byte(8'hA5, c);
    send_byte(8'h10, c);
    for (int i = 0; i < 63; i++) pulse_tick(t);
    idle(2);
    chk("to_early_err", err_n, 0);
    chk("to_early_busy", {31'd0, busy}, 32'd1);
    pulse_tick(t);
    idle(3);
    chk("to_err", err_n, 1);
    if (err_n > 0) chk("to_errcyc", err_cyc, t + 1);
    chk("to_code", {30'd0, err_code}, 32'd3);
    chk("to_busy", {31'd0, busy}, 32'd0);

    // A byte in the same cycle as the 64th tick wins over the timeout.
    clear_mon();
    send_byte(8'hA5, c);
    send_byte(8'h10, c);
    for (int i = 0; i < 63; i++) pulse_tick(t);
    @(posedge clk); #1;
    baud_tick = 1'b1; rx_valid = 1'b1; rx_data = 8'h03;
    @(posedge clk); #1;
    baud_tick = 1'b0; rx_valid = 1'b0;
    send_byte(8'h11, c);
    send_byte(8'h22, c);
    send_byte(8'h33, c);
    send_byte(8'h13, c);
    idle(24);
    chk("tie_err", err_n, 0);
    chk("tie_nwr", wa_q.size(), 3);
    chk("tie_ok", ok_n, 1);
    chk("tie_code", {30'd0, err_code}, 32'd3);

    // 16-byte frame with the next SYNC arriving on drain cycle 2.
    clear_mon();
    send_byte(8'hA5, c);
    send_byte(8'h40, c);
    send_byte(8'h10, c);
    cs = 8'h40 ^ 8'h10;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i + 1), c);
      cs = cs ^ (i + 1);
    end
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'(cs); C = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'hA5;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    idle(20);
    chk("hold_nwr", wa_q.size(), 16);
    for (int k = 0; k < 16 && k < wa_q.size(); k++) begin
      chk($sformatf("hold_addr%0d", k), {24'd0, wa_q[k]}, 32'h40 + k);
      chk($sformatf("hold_data%0d", k), {24'd0, wd_q[k]}, k + 1);
      chk($sformatf("hold_wcyc%0d", k), wc_q[k], C + 1 + k);
    end
    chk("hold_ok", ok_n, 1);
    if (ok_n > 0) chk("hold_okcyc", ok_cyc, C + 17);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    clear_mon();
    send_byte(8'h10, c);
    send_byte(8'h03, c);
    send_byte(8'h11, c);
    send_byte(8'h22, c);
    send_byte(8'h33, c);
    send_byte(8'h13, c);
    idle(24);
    chk("next_nwr", wa_q.size(), 3);
    for (int k = 0; k < 3 && k < wa_q.size(); k++) begin
      chk($sformatf("next_addr%0d", k), {24'd0, wa_q[k]}, {24'd0, exp_a[k]});
      chk($sformatf("next_data%0d", k), {24'd0, wd_q[k]}, {24'd0, exp_d[k]});
    end
    chk("next_ok", ok_n, 1);
    chk("next_err", err_n, 0);

    // Reset on drain cycle 5 of a 16-byte frame.
    clear_mon();
    send_byte(8'hA5, c);
    send_byte(8'h40, c);
    send_byte(8'h10, c);
    cs = 8'h40 ^ 8'h10;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i + 1), c);
      cs = cs ^ (i + 1);
    end
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'(cs); C = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rd_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rd_busy0", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(24);
    chk("rd_nwr", wa_q.size(), 6);
    chk("rd_ok", ok_n, 0);
    chk("rd_err", err_n, 0);
    chk("rd_busy", {31'd0, busy}, 32'd0);
    chk("rd_code", {30'd0, err_code}, 32'd0);
    chk("rd_addr", {24'd0, wr_addr}, 32'd0);

    chk("ok_err_exclusive", both_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
